// File: rtl/div_share_sched.sv
// div_share_sched: round-robin sharing of one pipelined signed divider among N requesters.
// Optional DIV0_FLAG_EN: flag den==0 per response, forcing coc to all ones and res to 0.
module div_share_sched #(
    parameter int W         = 32,
    parameter int N         = 4,
    parameter int RSP_DEPTH = 2
) (
    input  logic           CLK,
    input  logic           RSTa,
    input  logic [N-1:0]   req_valid,
    output logic [N-1:0]   req_ready,
    input  logic [N*W-1:0] req_num,
    input  logic [N*W-1:0] req_den,
    output logic [N-1:0]   rsp_valid,
    input  logic [N-1:0]   rsp_ready,
    output logic [N*W-1:0] rsp_coc,
    output logic [N*W-1:0] rsp_res,
    output logic           div_start,
    output logic [W-1:0]   div_num,
    output logic [W-1:0]   div_den,
    input  logic [W-1:0]   div_coc,
    input  logic [W-1:0]   div_res,
    input  logic           div_done,
    output logic           tag_err
`ifdef DIV0_FLAG_EN
    ,
    output logic [N-1:0]   rsp_div0
`endif
);
    localparam int LAT = 2 * W + 1;
    localparam int IW  = (N > 1) ? $clog2(N) : 1;
    localparam int PW  = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam int CW  = $clog2(RSP_DEPTH + 1) + 1;

    typedef struct packed {
        logic          vld;
        logic [IW-1:0] id;
`ifdef DIV0_FLAG_EN
        logic          div0;
`endif
    } tag_t;

    tag_t          tag_q [LAT];
    tag_t          tag_d;
    logic [IW-1:0] ptr_q;
    logic [CW-1:0] infl_q [N];
    logic [CW-1:0] cnt_q  [N];
    logic [PW-1:0] wp_q   [N];
    logic [PW-1:0] rp_q   [N];
    logic [W-1:0]  coc_q  [N][RSP_DEPTH];
    logic [W-1:0]  res_q  [N][RSP_DEPTH];
`ifdef DIV0_FLAG_EN
    logic          d0_q   [N][RSP_DEPTH];
`endif
    logic          tag_err_q;

    logic [N-1:0]  elig;
    logic [N-1:0]  grant;
    logic [N-1:0]  push;
    logic [N-1:0]  pop;
    logic [IW-1:0] gidx;
    logic [IW-1:0] idx;
    logic          found;
    logic [W-1:0]  cmp_coc;
    logic [W-1:0]  cmp_res;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(RSP_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Credit: a slot counts from grant until its response is popped.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            elig[i] = RSTa && req_valid[i]
                   && ((infl_q[i] + cnt_q[i]) < CW'(RSP_DEPTH));
        end
    end

    always_comb begin
        grant = '0;
        gidx  = '0;
        idx   = '0;
        found = 1'b0;
        for (int k = 1; k <= N; k++) begin
            idx = IW'((int'(ptr_q) + k) % N);
            if (!found && elig[idx]) begin
                found       = 1'b1;
                gidx        = idx;
                grant[idx]  = 1'b1;
            end
        end
    end

    always_comb begin
        div_num = '0;
        div_den = '0;
        for (int i = 0; i < N; i++) begin
            if (grant[i]) begin
                div_num = req_num[i*W +: W];
                div_den = req_den[i*W +: W];
            end
        end
    end

    assign req_ready = grant;
    assign div_start = found;
    assign tag_err   = tag_err_q;

    always_comb begin
        tag_d     = '0;
        tag_d.vld = found;
        tag_d.id  = gidx;
`ifdef DIV0_FLAG_EN
        tag_d.div0 = found && (div_den == '0);
`endif
    end

    always_comb begin
        push = '0;
        if (tag_q[0].vld) push[tag_q[0].id] = 1'b1;
    end

`ifdef DIV0_FLAG_EN
    assign cmp_coc = tag_q[0].div0 ? '1 : div_coc;
    assign cmp_res = tag_q[0].div0 ? '0 : div_res;
`else
    assign cmp_coc = div_coc;
    assign cmp_res = div_res;
`endif

    for (genvar i = 0; i < N; i++) begin : g_rsp
        assign rsp_valid[i]      = (cnt_q[i] != '0);
        assign pop[i]            = rsp_valid[i] && rsp_ready[i];
        assign rsp_coc[i*W +: W] = rsp_valid[i] ? coc_q[i][rp_q[i]] : '0;
        assign rsp_res[i*W +: W] = rsp_valid[i] ? res_q[i][rp_q[i]] : '0;
`ifdef DIV0_FLAG_EN
        assign rsp_div0[i]       = rsp_valid[i] && d0_q[i][rp_q[i]];
`endif
    end

    always_ff @(posedge CLK or negedge RSTa) begin
        if (!RSTa) begin
            ptr_q     <= IW'(N - 1);
            tag_err_q <= 1'b0;
            for (int s = 0; s < LAT; s++) tag_q[s] <= '0;
            for (int i = 0; i < N; i++) begin
                infl_q[i] <= '0;
                cnt_q[i]  <= '0;
                wp_q[i]   <= '0;
                rp_q[i]   <= '0;
            end
        end else begin
            if (found) ptr_q <= gidx;
            for (int s = 0; s < LAT - 1; s++) tag_q[s] <= tag_q[s+1];
            tag_q[LAT-1] <= tag_d;
            if (div_done != tag_q[0].vld) tag_err_q <= 1'b1;
            for (int i = 0; i < N; i++) begin
                if (grant[i] && !push[i]) begin
                    infl_q[i] <= infl_q[i] + CW'(1);
                end else if (!grant[i] && push[i]) begin
                    infl_q[i] <= infl_q[i] - CW'(1);
                end
                if (push[i] && !pop[i]) begin
                    cnt_q[i] <= cnt_q[i] + CW'(1);
                end else if (!push[i] && pop[i]) begin
                    cnt_q[i] <= cnt_q[i] - CW'(1);
                end
                if (push[i]) wp_q[i] <= nxt(wp_q[i]);
                if (pop[i])  rp_q[i] <= nxt(rp_q[i]);
            end
        end
    end

    always_ff @(posedge CLK) begin
        for (int i = 0; i < N; i++) begin
            if (push[i]) begin
                coc_q[i][wp_q[i]] <= cmp_coc;
                res_q[i][wp_q[i]] <= cmp_res;
`ifdef DIV0_FLAG_EN
                d0_q[i][wp_q[i]]  <= tag_q[0].div0;
`endif
            end
        end
    end

endmodule

// File: tb/tb_div_share_sched.sv
// tb_div_share_sched: vector table plus per-requester scoreboard for div_share_sched.
// A behavioural pipelined divider of the same latency stands in for the real divider.
`timescale 1ns/1ps
module tb_div_share_sched;
    localparam int W   = 8;
    localparam int N   = 4;
    localparam int LAT = 2 * W + 1;

    logic           CLK = 1'b0;
    logic           RSTa = 1'b0;
    logic [N-1:0]   req_valid = '1;
    logic [N-1:0]   req_ready;
    logic [N*W-1:0] req_num = '1;
    logic [N*W-1:0] req_den = '1;
    logic [N-1:0]   rsp_valid;
    logic [N-1:0]   rsp_ready = '1;
    logic [N*W-1:0] rsp_coc;
    logic [N*W-1:0] rsp_res;
    logic           div_start;
    logic [W-1:0]   div_num;
    logic [W-1:0]   div_den;
    logic [W-1:0]   div_coc;
    logic [W-1:0]   div_res;
    logic           div_done;
    logic           tag_err;
`ifdef DIV0_FLAG_EN
    logic [N-1:0]   rsp_div0;
`endif

    always #5 CLK = ~CLK;

    div_share_sched #(.W(W), .N(N), .RSP_DEPTH(2)) dut (
        .CLK(CLK), .RSTa(RSTa),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_num(req_num), .req_den(req_den),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_coc(rsp_coc), .rsp_res(rsp_res),
        .div_start(div_start), .div_num(div_num), .div_den(div_den),
        .div_coc(div_coc), .div_res(div_res), .div_done(div_done),
        .tag_err(tag_err)
`ifdef DIV0_FLAG_EN
        , .rsp_div0(rsp_div0)
`endif
    );

    // Behavioural divider: den==0 yields all ones and the numerator.
    function automatic logic [2*W-1:0] raw_div(input logic [W-1:0] n,
                                               input logic [W-1:0] d);
        logic [W-1:0] q;
        logic [W-1:0] r;
        if (d == '0) begin
            q = '1;
            r = n;
        end else begin
            q = $signed(n) / $signed(d);
            r = $signed(n) % $signed(d);
        end
        return {q, r};
    endfunction

    logic [2*W-1:0] mp [LAT];
    logic           mv [LAT];

    always @(posedge CLK or negedge RSTa) begin
        if (!RSTa) begin
            for (int s = 0; s < LAT; s++) begin
                mv[s] <= 1'b0;
                mp[s] <= '0;
            end
        end else begin
            for (int s = 0; s < LAT - 1; s++) begin
                mv[s] <= mv[s+1];
                mp[s] <= mp[s+1];
            end
            mv[LAT-1] <= div_start;
            mp[LAT-1] <= raw_div(div_num, div_den);
        end
    end

    assign div_done = mv[0];
    assign div_coc  = mp[0][2*W-1:W];
    assign div_res  = mp[0][W-1:0];

    typedef struct packed {
        logic         z;
        logic [W-1:0] q;
        logic [W-1:0] r;
    } res_t;

    typedef struct {
        int           req;
        logic [W-1:0] num;
        logic [W-1:0] den;
        logic [W-1:0] coc;
        logic [W-1:0] res;
        logic         z;
    } vec_t;

    function automatic res_t exp_of(input logic [W-1:0] n,
                                    input logic [W-1:0] d);
        res_t e;
        e.z = 1'b0;
        {e.q, e.r} = raw_div(n, d);
`ifdef DIV0_FLAG_EN
        if (d == '0) begin
            e.z = 1'b1;
            e.q = '1;
            e.r = '0;
        end
`endif
        return e;
    endfunction

    int           checks = 0;
    int           errors = 0;
    res_t         sbq [N][$];
    logic [N-1:0] acc_last = '0;
    logic [N-1:0] auto_en = '0;
    int           acc_cnt [N];
    vec_t         vt [6];

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    function automatic logic [W-1:0] rnd_num();
        logic [W-1:0] v;
        v = W'($urandom_range(0, 255));
        if (v == 8'h80) v = 8'h81;
        return v;
    endfunction

    function automatic logic [W-1:0] rnd_den();
        return W'($urandom_range(1, 255));
    endfunction

    task automatic rnd_req(input int i);
        req_num[i*W +: W] = rnd_num();
        req_den[i*W +: W] = rnd_den();
    endtask

    // Sample at the falling edge: record accepts, pop and compare responses.
    task automatic sample();
        res_t e;
        @(negedge CLK);
        if (!RSTa) begin
            for (int i = 0; i < N; i++) sbq[i].delete();
            acc_last = '0;
        end else begin
            acc_last = req_valid & req_ready;
            for (int i = 0; i < N; i++) begin
                if (acc_last[i]) begin
                    acc_cnt[i]++;
                    sbq[i].push_back(exp_of(req_num[i*W +: W], req_den[i*W +: W]));
                end
                if (rsp_valid[i] && rsp_ready[i]) begin
                    if (sbq[i].size() == 0) begin
                        check("sb_unexpected_rsp", 32'(i), 32'hFFFF);
                    end else begin
                        e = sbq[i].pop_front();
                        check("sb_coc", 32'(rsp_coc[i*W +: W]), 32'(e.q));
                        check("sb_res", 32'(rsp_res[i*W +: W]), 32'(e.r));
`ifdef DIV0_FLAG_EN
                        check("sb_div0", 32'(rsp_div0[i]), 32'(e.z));
`endif
                    end
                end
            end
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
        for (int i = 0; i < N; i++) begin
            if (auto_en[i] && acc_last[i]) rnd_req(i);
        end
    endtask

    task automatic tick();
        sample();
        step();
    endtask

    task automatic do_reset();
        RSTa = 1'b0;
        tick();
        tick();
        RSTa = 1'b1;
    endtask

    task automatic check_idle_outputs(input string nm);
        check({nm, "_req_ready"}, 32'(req_ready), 32'h0);
        check({nm, "_div_start"}, 32'(div_start), 32'h0);
        check({nm, "_div_num"}, 32'(div_num), 32'h0);
        check({nm, "_div_den"}, 32'(div_den), 32'h0);
        check({nm, "_rsp_valid"}, 32'(rsp_valid), 32'h0);
        check({nm, "_rsp_coc"}, rsp_coc, 32'h0);
        check({nm, "_rsp_res"}, rsp_res, 32'h0);
        check({nm, "_tag_err"}, 32'(tag_err), 32'h0);
    endtask

    task automatic apply_vec(input int v);
        int r;
        int n;
        r = vt[v].req;
        req_num[r*W +: W] = vt[v].num;
        req_den[r*W +: W] = vt[v].den;
        req_valid = '0;
        req_valid[r] = 1'b1;
        n = 0;
        sample();
        while (!req_ready[r] && n < 20) begin
            step();
            sample();
            n++;
        end
        check("vec_accept", 32'(req_ready[r]), 32'h1);
        step();
        req_valid = '0;
        n = 1;
        sample();
        while (!rsp_valid[r] && n < 40) begin
            step();
            sample();
            n++;
        end
        check("vec_latency", 32'(n), 32'(LAT + 1));
        check("vec_coc", 32'(rsp_coc[r*W +: W]), 32'(vt[v].coc));
        check("vec_res", 32'(rsp_res[r*W +: W]), 32'(vt[v].res));
`ifdef DIV0_FLAG_EN
        check("vec_div0", 32'(rsp_div0[r]), 32'(vt[v].z));
`endif
        check("vec_tag_err", 32'(tag_err), 32'h0);
        step();
    endtask

    initial begin
        int b [N];
        for (int i = 0; i < N; i++) acc_cnt[i] = 0;
        vt[0] = '{0, 8'd100, 8'd7,   8'd14,  8'd2,  1'b0};
        vt[1] = '{2, 8'h9C,  8'd7,   8'hF2,  8'hFE, 1'b0};
        vt[2] = '{1, 8'd100, 8'hF9,  8'hF2,  8'h02, 1'b0};
        vt[3] = '{1, 8'd7,   8'd100, 8'h00,  8'h07, 1'b0};
        vt[4] = '{3, 8'hF9,  8'd2,   8'hFD,  8'hFF, 1'b0};
`ifdef DIV0_FLAG_EN
        vt[5] = '{3, 8'd5,   8'd0,   8'hFF,  8'h00, 1'b1};
`else
        vt[5] = '{3, 8'd5,   8'd0,   8'hFF,  8'h05, 1'b0};
`endif

        // Reset with all requests asserted: every output must stay 0.
        step();
        sample();
        check_idle_outputs("reset");
        step();
        RSTa = 1'b1;
        req_valid = '0;
        rsp_ready = '1;

        for (int v = 0; v < 6; v++) apply_vec(v);

        // Round robin with all four requesters, then credit stall.
        do_reset();
        for (int i = 0; i < N; i++) rnd_req(i);
        req_valid = '1;
        auto_en = '1;
        for (int k = 0; k < 8; k++) begin
            sample();
            check("rr_grant", 32'(req_ready), 32'(1 << (k % 4)));
            step();
        end
        for (int k = 8; k < 19; k++) begin
            sample();
            check("rr_stall", 32'(req_ready), 32'h0);
            step();
        end
        sample();
        check("rr_resume", 32'(req_ready), 32'h1);
        step();
        repeat (60) tick();
        req_valid = '0;
        auto_en = '0;
        repeat (40) tick();
        for (int i = 0; i < N; i++) check("rr_drain", 32'(sbq[i].size()), 32'h0);

        // Blocked response port on requester 1.
        rsp_ready = 4'b1101;
        req_valid = '1;
        auto_en = '1;
        for (int i = 0; i < N; i++) b[i] = acc_cnt[i];
        repeat (40) tick();
        sample();
        check("blk_req1_accepts", 32'(acc_cnt[1] - b[1]), 32'd2);
        check("blk_req1_ready", 32'(req_ready[1]), 32'h0);
        check("blk_req1_rsp_valid", 32'(rsp_valid[1]), 32'h1);
        check("blk_req0_free", 32'(acc_cnt[0] - b[0] >= 4), 32'h1);
        check("blk_req2_free", 32'(acc_cnt[2] - b[2] >= 4), 32'h1);
        check("blk_req3_free", 32'(acc_cnt[3] - b[3] >= 4), 32'h1);
        step();
        rsp_ready = '1;
        sample();
        step();
        rsp_ready = 4'b1101;
        b[1] = acc_cnt[1];
        repeat (30) tick();
        sample();
        check("blk_one_pop_one_grant", 32'(acc_cnt[1] - b[1]), 32'd1);
        check("blk_req1_ready_again", 32'(req_ready[1]), 32'h0);
        step();
        req_valid = '0;
        auto_en = '0;
        rsp_ready = '1;
        repeat (40) tick();
        for (int i = 0; i < N; i++) check("blk_drain", 32'(sbq[i].size()), 32'h0);

        // Reset with three divisions in flight.
        do_reset();
        for (int i = 0; i < N; i++) b[i] = acc_cnt[i];
        for (int i = 0; i < N; i++) rnd_req(i);
        req_valid = 4'b0111;
        auto_en = 4'b0111;
        repeat (3) tick();
        req_valid = '0;
        auto_en = '0;
        repeat (4) tick();
        check("mid_inflight", 32'(acc_cnt[0] + acc_cnt[1] + acc_cnt[2]
                                  - b[0] - b[1] - b[2]), 32'd3);
        RSTa = 1'b0;
        req_valid = '1;
        sample();
        check_idle_outputs("mid_reset");
        step();
        sample();
        check_idle_outputs("mid_reset2");
        step();
        RSTa = 1'b1;
        req_valid = '0;
        for (int k = 0; k < 40; k++) begin
            sample();
            check("post_reset_rsp", 32'(rsp_valid), 32'h0);
            step();
        end
        check("post_reset_tag_err", 32'(tag_err), 32'h0);
        apply_vec(0);
        apply_vec(1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
